mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares one single-ported memory between the core's instruction-fetch port and its data
//   (load/store) port. Fixed priority to data, bounded by an anti-starvation counter; one
//   transaction outstanding at a time; watchdog aborts a hung memory. Sits between ezpipe
//   ibus/dbus and the on-chip RAM.
// PARAMETERS
//   MAX_D_RUN  4     consecutive data grants allowed while i_req is pending (1..15)
//   TIMEOUT    255   cycles without mem_ready before abort (1..255)
// PORTS
//   clk        in   1   clock, all state on posedge
//   reset_n    in   1   asynchronous, active-low reset
//   i_req      in   1   fetch request, held until i_ready or i_err
//   i_addr     in   32  fetch byte address, stable while i_req
//   i_rdata    out  32  fetch data, valid with i_ready
//   i_ready    out  1   one-cycle fetch completion pulse
//   i_err      out  1   one-cycle fetch timeout pulse
//   d_req      in   1   data request, held until d_ready or d_err
//   d_we       in   1   1 = store, 0 = load; stable while d_req
//   d_addr     in   32  data byte address
//   d_wdata    in   32  store data
//   d_wstrb    in   4   store byte enables
//   d_rdata    out  32  load data, valid with d_ready
//   d_ready    out  1   one-cycle data completion pulse
//   d_err      out  1   one-cycle data timeout pulse
//   mem_req    out  1   memory request, held until mem_ready or abort
//   mem_we     out  1   memory write enable
//   mem_addr   out  32  memory address, {addr[31:2],2'b00}
//   mem_wdata  out  32  memory write data
//   mem_wstrb  out  4   memory byte enables (4'b0000 for reads)
//   mem_rdata  in   32  memory read data, valid with mem_ready
//   mem_ready  in   1   memory completion pulse
// BEHAVIOUR
//   - Reset: state IDLE, run count 0, timer 0; all outputs 0.
//   - States: IDLE, GNT_I, GNT_D. Grant is registered: request sampled in IDLE at edge N,
//     mem_req high from cycle N+1. Min latency req->ready = 2 cycles.
//   - IDLE arbitration: d_req only -> GNT_D; i_req only -> GNT_I; both -> GNT_D unless
//     run count == MAX_D_RUN, then GNT_I. Neither -> stay.
//   - Run count: +1 on each GNT_D entry while i_req high, saturating at MAX_D_RUN; cleared
//     on GNT_I entry or when i_req low at a GNT_D entry.
//   - GNT_x: mem_* driven from the granted port's inputs combinationally. On mem_ready:
//     x_ready=1, x_rdata=mem_rdata (combinational pass-through, 0 otherwise), next state IDLE.
//     Always one IDLE bubble between transactions; completed requester must drop req or
//     present a new one in that bubble cycle (a held req is a new request).
//   - Watchdog: 8-bit timer cleared on grant entry, +1 each GNT_x cycle without mem_ready;
//     at TIMEOUT: x_err=1, mem_req=0, next IDLE. mem_ready in the same cycle wins (ready, not err).
//   - mem_ready in IDLE is ignored. x_ready/x_err never both high; never asserted for the
//     non-granted port. Requester dropping req mid-grant: illegal, transaction still completes.
//   - Async reset mid-transaction: immediately IDLE, mem_req=0, no ready/err pulse.
// STRUCTURE
//   - Shared package: state encoding ARB_IDLE/ARB_GNT_I/ARB_GNT_D (2 bits); these state
//     constants are reused by the pipeline stall logic.
//   - Single module; no sub-module. Output mux is combinational on state.
// TESTING
//   - Reset release, no req -> mem_req=0 forever; all outputs 0.
//   - i_req, addr 0x104, mem_ready 1 cycle after mem_req, rdata 0x00000013 -> mem_addr=0x104,
//     mem_we=0, i_ready pulse with i_rdata=0x13 at cycle 2.
//   - i_req and d_req (store 0xDEADBEEF @0x200, wstrb 4'hF) same cycle -> data granted first,
//     mem_we=1, wstrb=F; fetch granted after d_ready + 1 bubble.
//   - d_req held continuously with i_req, MAX_D_RUN=4 -> exactly 4 data grants, then 1 fetch.
//   - mem_ready never arrives, TIMEOUT=255 -> d_err pulse 255 cycles after grant, mem_req low
//     next cycle; mem_ready on the timeout cycle -> d_ready, no d_err.
//   - reset_n low while GNT_D -> mem_req drops asynchronously, no d_ready/d_err; re-arbitrates
//     from IDLE after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// The state encoding is also consumed by the pipeline stall logic.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_e;

  localparam int RUN_W   = 4;
  localparam int TIMER_W = 8;

  // Memory is word addressed on the bus; byte offset is carried by the strobes.
  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, the load/store port and the memory port of the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_arbiter_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        i_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        d_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  i_req, i_addr,
    output i_rdata, i_ready, i_err,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_rdata, d_ready, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready
  );

  modport master (
    output i_req, i_addr,
    input  i_rdata, i_ready, i_err,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_rdata, d_ready, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-ported memory arbiter: data has priority, bounded by an anti-starvation run count,
// one transaction outstanding, watchdog abort of a hung memory.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_D_RUN = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_arbiter_if.slave bus
);

  localparam logic [RUN_W-1:0]   MAX_RUN     = RUN_W'(MAX_D_RUN);
  localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(TIMEOUT);

  arb_state_e         state, state_nx;
  logic [RUN_W-1:0]   run_cnt, run_nx;
  logic [TIMER_W-1:0] timer, timer_nx;

  logic gnt_i, gnt_d, timer_hit, abort;
  logic i_done, d_done;

  assign gnt_i     = (state == ARB_GNT_I);
  assign gnt_d     = (state == ARB_GNT_D);
  assign timer_hit = (gnt_i | gnt_d) & (timer == TIMEOUT_VAL);
  // A completion arriving on the timeout cycle wins over the abort.
  assign abort     = timer_hit & ~bus.mem_ready;
  assign i_done    = gnt_i & bus.mem_ready;
  assign d_done    = gnt_d & bus.mem_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ARB_IDLE;
      run_cnt <= '0;
      timer   <= '0;
    end else begin
      state   <= state_nx;
      run_cnt <= run_nx;
      timer   <= timer_nx;
    end
  end

  always_comb begin
    state_nx = state;
    run_nx   = run_cnt;
    timer_nx = timer;
    case (state)
      ARB_IDLE: begin
        timer_nx = '0;
        if (bus.d_req && !(bus.i_req && run_cnt == MAX_RUN)) begin
          state_nx = ARB_GNT_D;
          // Only consecutive data wins against a waiting fetch count toward starvation.
          if (!bus.i_req)
            run_nx = '0;
          else if (run_cnt != MAX_RUN)
            run_nx = run_cnt + 1'b1;
        end else if (bus.i_req) begin
          state_nx = ARB_GNT_I;
          run_nx   = '0;
        end
      end
      ARB_GNT_I, ARB_GNT_D: begin
        if (bus.mem_ready || timer_hit)
          state_nx = ARB_IDLE;
        else
          timer_nx = timer + 1'b1;
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  assign bus.mem_req   = (gnt_i | gnt_d) & ~timer_hit;
  assign bus.mem_we    = gnt_d & bus.d_we;
  assign bus.mem_addr  = gnt_d ? word_addr(bus.d_addr) :
                         gnt_i ? word_addr(bus.i_addr) : 32'h0;
  assign bus.mem_wdata = gnt_d ? bus.d_wdata : 32'h0;
  assign bus.mem_wstrb = (gnt_d & bus.d_we) ? bus.d_wstrb : 4'b0000;

  assign bus.i_ready = i_done;
  assign bus.i_rdata = i_done ? bus.mem_rdata : 32'h0;
  assign bus.i_err   = gnt_i & abort;

  assign bus.d_ready = d_done;
  assign bus.d_rdata = d_done ? bus.mem_rdata : 32'h0;
  assign bus.d_err   = gnt_d & abort;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model of arbitration and memory contents.
module tb_mem_arbiter;

  localparam int MAX_D_RUN = 4;
  localparam int TIMEOUT   = 255;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  int          mem_lat;
  int          wcnt;
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  mem_arbiter_if bus();

  mem_arbiter #(.MAX_D_RUN(MAX_D_RUN), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int w);
    logic [31:0] ww;
    ww = 32'(w);
    if (w == 'h41) return 32'h0000_0013;
    return (ww * 32'h0101_0101) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [137:0] all_outs();
    return {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb,
            bus.i_ready, bus.i_err, bus.d_ready, bus.d_err, bus.i_rdata, bus.d_rdata};
  endfunction

  // Memory model: answers mem_lat cycles after it first sees mem_req.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= 32'h0;
      wcnt          <= 0;
      for (int w = 0; w < 256; w++) mem[w] <= init_word(w);
    end else if (bus.mem_req && !bus.mem_ready) begin
      if (wcnt >= mem_lat) begin
        bus.mem_ready <= 1'b1;
        bus.mem_rdata <= mem[bus.mem_addr[9:2]];
        if (bus.mem_we)
          for (int b = 0; b < 4; b++)
            if (bus.mem_wstrb[b]) mem[bus.mem_addr[9:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
        wcnt <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= 32'h0;
      wcnt          <= 0;
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (all_outs() !== '0) begin
        errors++; $display("FAIL idle_outputs cycle %0d: got %h expected 0", c, all_outs());
      end
    end
  endtask

  task automatic test_fetch();
    mem_lat = 0;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h104;
    @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.i_ready} !== {1'b1, 1'b0, 32'h104, 4'h0, 1'b0}) begin
      errors++; $display("FAIL fetch_grant: req=%b we=%b addr=%h strb=%h rdy=%b expected 1 0 00000104 0 0",
                         bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.i_ready);
    end
    @(negedge clk);
    checks++;
    if ({bus.i_ready, bus.i_err, bus.i_rdata} !== {1'b1, 1'b0, 32'h13}) begin
      errors++; $display("FAIL fetch_ready: rdy=%b err=%b rdata=%h expected 1 0 00000013",
                         bus.i_ready, bus.i_err, bus.i_rdata);
    end
    @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.i_ready} !== 2'b00) begin
      errors++; $display("FAIL fetch_bubble: req=%b rdy=%b expected 0 0", bus.mem_req, bus.i_ready);
    end
    bus.i_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL fetch_after_drop: mem_req=%b expected 0", bus.mem_req);
    end
  endtask

  task automatic test_priority();
    int n;
    mem_lat = 0;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'hF;
    bus.i_req = 1'b1; bus.i_addr = 32'h104;
    @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !==
        {1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF}) begin
      errors++; $display("FAIL prio_data_first: req=%b we=%b addr=%h wdata=%h strb=%h expected 1 1 00000200 deadbeef f",
                         bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    end
    n = 0;
    while (!bus.d_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if ({bus.d_ready, bus.i_ready, bus.d_err} !== 3'b100) begin
      errors++; $display("FAIL prio_d_ready: d_rdy=%b i_rdy=%b d_err=%b expected 1 0 0", bus.d_ready, bus.i_ready, bus.d_err);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL prio_bubble: mem_req=%b expected 0", bus.mem_req);
    end
    bus.d_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h104}) begin
      errors++; $display("FAIL prio_fetch_next: req=%b we=%b addr=%h expected 1 0 00000104", bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    @(negedge clk);
    checks++;
    if ({bus.i_ready, bus.i_rdata} !== {1'b1, 32'h13}) begin
      errors++; $display("FAIL prio_fetch_ready: rdy=%b rdata=%h expected 1 00000013", bus.i_ready, bus.i_rdata);
    end
    checks++;
    if (mem[8'h80] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL prio_store_data: mem=%h expected deadbeef", mem[8'h80]);
    end
    @(negedge clk);
    bus.i_req = 1'b0;
  endtask

  task automatic test_run_limit();
    int gr_d, gr_i, dr, d_after_i;
    logic prev, fin;
    mem_lat = 0;
    gr_d = 0; gr_i = 0; dr = 0; d_after_i = 0; prev = 1'b0; fin = 1'b0;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300;
    bus.i_req = 1'b1; bus.i_addr = 32'h104;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.mem_req && !prev) begin
        if (bus.mem_addr == 32'h300) begin
          gr_d++;
          if (gr_i != 0) d_after_i++;
        end else gr_i++;
      end
      prev = bus.mem_req;
      if (bus.d_ready) dr++;
      if (bus.i_ready) begin fin = 1'b1; break; end
    end
    checks++;
    if ({fin, gr_d, gr_i, dr, d_after_i} !== {1'b1, MAX_D_RUN, 1, MAX_D_RUN, 0}) begin
      errors++; $display("FAIL run_limit: fetch_done=%b d_grants=%0d i_grants=%0d d_ready=%0d expected 1 %0d 1 %0d",
                         fin, gr_d, gr_i, dr, MAX_D_RUN, MAX_D_RUN);
    end
    @(negedge clk);
    bus.d_req = 1'b0; bus.i_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL run_limit_idle: mem_req=%b expected 0", bus.mem_req);
    end
  endtask

  task automatic test_timeout();
    int ev_at, high;
    logic rdy_seen, err_seen;
    mem_lat = 1000;
    ev_at = -1; high = 0; rdy_seen = 1'b0;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.d_ready) rdy_seen = 1'b1;
      if (bus.d_err) begin ev_at = c; break; end
      if (bus.mem_req) high++;
    end
    checks++;
    if ({ev_at, high, rdy_seen} !== {TIMEOUT, TIMEOUT, 1'b0}) begin
      errors++; $display("FAIL timeout_err: err_cycle=%0d req_cycles=%0d ready_seen=%b expected %0d %0d 0",
                         ev_at, high, rdy_seen, TIMEOUT, TIMEOUT);
    end
    @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.d_err, bus.d_ready} !== 3'b000) begin
      errors++; $display("FAIL timeout_after: req=%b err=%b rdy=%b expected 0 0 0", bus.mem_req, bus.d_err, bus.d_ready);
    end
    bus.d_req = 1'b0;
    mem_lat = TIMEOUT - 1;
    ev_at = -1; err_seen = 1'b0;
    @(negedge clk);
    bus.d_req = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.d_err) err_seen = 1'b1;
      if (bus.d_ready || bus.d_err) begin ev_at = c; break; end
    end
    checks++;
    if ({ev_at, err_seen, bus.d_ready, bus.d_rdata} !== {TIMEOUT, 1'b0, 1'b1, init_word('hC0)}) begin
      errors++; $display("FAIL timeout_ready_wins: cycle=%0d err=%b rdy=%b rdata=%h expected %0d 0 1 %h",
                         ev_at, err_seen, bus.d_ready, bus.d_rdata, TIMEOUT, init_word('hC0));
    end
    @(negedge clk);
    bus.d_req = 1'b0;
    mem_lat = 0;
  endtask

  task automatic test_async_reset();
    logic [31:0] exp_w;
    mem_lat = 1000;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h240;
    bus.d_wdata = 32'h1234_5678; bus.d_wstrb = 4'b0011;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++; $display("FAIL areset_pre: mem_req=%b expected 1", bus.mem_req);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_req, bus.d_ready, bus.d_err} !== 3'b000) begin
      errors++; $display("FAIL areset_immediate: req=%b rdy=%b err=%b expected 0 0 0", bus.mem_req, bus.d_ready, bus.d_err);
    end
    mem_lat = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.d_ready, bus.d_err} !== 3'b000) begin
        errors++; $display("FAIL areset_held: req=%b rdy=%b err=%b expected 0 0 0", bus.mem_req, bus.d_ready, bus.d_err);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_addr, bus.mem_wstrb} !== {1'b1, 32'h240, 4'b0011}) begin
      errors++; $display("FAIL areset_rearb: req=%b addr=%h strb=%h expected 1 00000240 3", bus.mem_req, bus.mem_addr, bus.mem_wstrb);
    end
    @(negedge clk);
    checks++;
    if (bus.d_ready !== 1'b1) begin
      errors++; $display("FAIL areset_complete: d_ready=%b expected 1", bus.d_ready);
    end
    @(negedge clk);
    bus.d_req = 1'b0;
    exp_w = init_word('h90);
    exp_w[15:0] = 16'h5678;
    checks++;
    if (mem[8'h90] !== exp_w) begin
      errors++; $display("FAIL areset_store: mem=%h expected %h", mem[8'h90], exp_w);
    end
  endtask

  task automatic test_random();
    int cur, nxt, run, done_cnt, idx, bad;
    logic rdy, i_done, d_done, drained;
    @(negedge clk);
    reset_n = 1'b0;
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int w = 0; w < 256; w++) ref_mem[w] = init_word(w);
    cur = 0; run = 0; done_cnt = 0; i_done = 1'b0; d_done = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rdy = 1'b0;
      checks++;
      if ((bus.i_ready && bus.d_ready) || bus.i_err || bus.d_err ||
          (!bus.i_ready && bus.i_rdata !== 32'h0) || (!bus.d_ready && bus.d_rdata !== 32'h0)) begin
        errors++; $display("FAIL rand_resp_excl cycle %0d: i_rdy=%b d_rdy=%b i_err=%b d_err=%b i_rd=%h d_rd=%h",
                           c, bus.i_ready, bus.d_ready, bus.i_err, bus.d_err, bus.i_rdata, bus.d_rdata);
      end
      if (cur == 2) begin
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.i_ready} !==
            {1'b1, bus.d_we, bus.d_addr & ~32'h3, bus.d_we ? bus.d_wstrb : 4'h0, 1'b0}) begin
          errors++; $display("FAIL rand_d_bus cycle %0d: req=%b we=%b addr=%h strb=%h i_rdy=%b for d_addr=%h d_we=%b",
                             c, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.i_ready, bus.d_addr, bus.d_we);
        end
        if (bus.d_we) begin
          checks++;
          if (bus.mem_wdata !== bus.d_wdata) begin
            errors++; $display("FAIL rand_d_wdata cycle %0d: got %h expected %h", c, bus.mem_wdata, bus.d_wdata);
          end
        end
        if (bus.d_ready) begin
          rdy = 1'b1; d_done = 1'b1; done_cnt++;
          idx = int'(bus.d_addr[9:2]);
          if (bus.d_we) begin
            for (int b = 0; b < 4; b++)
              if (bus.d_wstrb[b]) ref_mem[idx][b*8 +: 8] = bus.d_wdata[b*8 +: 8];
          end else begin
            checks++;
            if (bus.d_rdata !== ref_mem[idx]) begin
              errors++; $display("FAIL rand_d_rdata cycle %0d: got %h expected %h", c, bus.d_rdata, ref_mem[idx]);
            end
          end
        end
      end else if (cur == 1) begin
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.d_ready} !==
            {1'b1, 1'b0, bus.i_addr & ~32'h3, 4'h0, 1'b0}) begin
          errors++; $display("FAIL rand_i_bus cycle %0d: req=%b we=%b addr=%h strb=%h d_rdy=%b for i_addr=%h",
                             c, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.d_ready, bus.i_addr);
        end
        if (bus.i_ready) begin
          rdy = 1'b1; i_done = 1'b1; done_cnt++;
          idx = int'(bus.i_addr[9:2]);
          checks++;
          if (bus.i_rdata !== ref_mem[idx]) begin
            errors++; $display("FAIL rand_i_rdata cycle %0d: got %h expected %h", c, bus.i_rdata, ref_mem[idx]);
          end
        end
      end else begin
        checks++;
        if ({bus.mem_req, bus.i_ready, bus.d_ready} !== 3'b000) begin
          errors++; $display("FAIL rand_idle cycle %0d: req=%b i_rdy=%b d_rdy=%b expected 0 0 0",
                             c, bus.mem_req, bus.i_ready, bus.d_ready);
        end
      end

      if (cur != 0) begin
        nxt = rdy ? 0 : cur;
      end else begin
        // Bubble: finished requesters either drop or present a new request.
        if (i_done) begin
          i_done = 1'b0;
          bus.i_req = 1'b0;
          if ($urandom_range(0, 1) == 1) begin bus.i_req = 1'b1; bus.i_addr = $urandom_range(0, 1023); end
        end
        if (d_done) begin
          d_done = 1'b0;
          bus.d_req = 1'b0;
          if ($urandom_range(0, 1) == 1) begin
            bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(0, 1)); bus.d_addr = $urandom_range(0, 1023);
            bus.d_wdata = $urandom; bus.d_wstrb = 4'($urandom_range(0, 15));
          end
        end
        nxt = 0;
      end
      if (!bus.i_req && !i_done && $urandom_range(0, 2) == 0) begin
        bus.i_req = 1'b1; bus.i_addr = $urandom_range(0, 1023);
      end
      if (!bus.d_req && !d_done && $urandom_range(0, 2) == 0) begin
        bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(0, 1)); bus.d_addr = $urandom_range(0, 1023);
        bus.d_wdata = $urandom; bus.d_wstrb = 4'($urandom_range(0, 15));
      end
      // Reference arbitration: data wins unless fetch has waited through MAX_D_RUN data wins.
      if (cur == 0) begin
        if (bus.d_req && !(bus.i_req && run == MAX_D_RUN)) begin
          nxt = 2;
          run = bus.i_req ? ((run < MAX_D_RUN) ? run + 1 : run) : 0;
          mem_lat = $urandom_range(0, 3);
        end else if (bus.i_req) begin
          nxt = 1;
          run = 0;
          mem_lat = $urandom_range(0, 3);
        end
      end
      cur = nxt;
    end

    drained = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!bus.mem_req) begin
        bus.i_req = 1'b0; bus.d_req = 1'b0; drained = 1'b1;
        break;
      end
    end
    checks++;
    if (!drained || done_cnt < 100) begin
      errors++; $display("FAIL rand_progress: drained=%b completions=%0d expected 1 and >=100", drained, done_cnt);
    end
    @(negedge clk);
    bad = 0;
    for (int w = 0; w < 256; w++) if (mem[w] !== ref_mem[w]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rand_mem_contents: %0d words differ, expected 0", bad);
    end
  endtask

  initial begin
    checks = 0; errors = 0; mem_lat = 0;
    reset_n = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0; bus.d_wstrb = 4'h0;
    test_reset();
    test_fetch();
    test_priority();
    test_run_limit();
    test_timeout();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
